// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command controller slice.
package spi_pkg;

  typedef enum logic [1:0] {
    CMD,
    WRITE,
    READ
  } spi_state_t;

  localparam int CMD_WRITE_BIT = 7;
  localparam int BYTE_W        = 8;

endpackage

// File: rtl/spi_addr_ctr.sv
// Loadable register-address counter, shared by the write and readback paths.
// Wraps NUM_REGS-1 -> 0; addresses above the implemented range count modulo 2^ADDR_W.
module spi_addr_ctr #(
  parameter int ADDR_W   = 7,
  parameter int NUM_REGS = 64
) (
  input  logic              spi_clk,
  input  logic              full_rstn,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              in_range_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;

  // NOTE: addr_d takes a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_addr_i;
    end else if (inc_i) begin
      addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge spi_clk or negedge full_rstn) begin
    if (!full_rstn) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o     = addr_q;
  assign in_range_o = (32'(addr_q) < NUM_REGS);

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Byte-level SPI command controller: command/address byte, then auto-incrementing data burst.
// Define SPI_READBACK_EN to enable register readback on poci; otherwise rd_addr and poci stay 0.
module spi_cmd_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int NUM_REGS = 64
) (
  input  logic              spi_clk,
  input  logic              full_rstn,
  input  logic              pico,
  input  logic [BYTE_W-1:0] byte_deser,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [BYTE_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [BYTE_W-1:0] rd_data,
  output logic              poci,
  output logic              addr_err
);

  logic [2:0]        bit_cnt_q, bit_cnt_d;
  spi_state_t        state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0] wr_data_q, wr_data_d;
  logic              addr_err_q, addr_err_d;

  logic              byte_done;
  logic [BYTE_W-1:0] byte_in;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_in_range;
  logic              ctr_load, ctr_inc;
  logic              rd_step, rd_err;
  logic              unused_bits;

  // The 8th edge completes a byte; the deserializer has not yet shifted in this bit.
  assign byte_done = (bit_cnt_q == 3'd7);
  assign byte_in   = {byte_deser[BYTE_W-2:0], pico};
  assign bit_cnt_d = bit_cnt_q + 3'd1;

  assign ctr_load = byte_done && (state_q == CMD);
  assign ctr_inc  = (byte_done && (state_q == WRITE)) || rd_step;

  spi_addr_ctr #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_addr_ctr (
    .spi_clk     (spi_clk),
    .full_rstn   (full_rstn),
    .load_i      (ctr_load),
    .inc_i       (ctr_inc),
    .load_addr_i (byte_in[ADDR_W-1:0]),
    .addr_o      (cur_addr),
    .in_range_o  (cur_in_range)
  );

  // Only the command byte moves the FSM; WRITE and READ hold until cs drops.
  always_comb begin
    state_d = state_q;
    if (byte_done && (state_q == CMD)) begin
      state_d = byte_in[CMD_WRITE_BIT] ? WRITE : READ;
    end
  end

  always_comb begin
    wr_en_d   = byte_done && (state_q == WRITE) && cur_in_range;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_en_d) begin
      wr_addr_d = cur_addr;
      wr_data_d = byte_in;
    end
    addr_err_d = addr_err_q | rd_err |
                 (byte_done && (state_q == WRITE) && !cur_in_range);
  end

  always_ff @(posedge spi_clk or negedge full_rstn) begin
    if (!full_rstn) begin
      bit_cnt_q  <= '0;
      state_q    <= CMD;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign addr_err = addr_err_q;

`ifdef SPI_READBACK_EN
  logic [BYTE_W-1:0] shift_q, shift_d;

  assign rd_step = byte_done && (state_q == READ);
  assign rd_err  = rd_step && !cur_in_range;

  // Load on each READ byte boundary, so the byte right after the command is a dummy.
  always_comb begin
    shift_d = {shift_q[BYTE_W-2:0], 1'b0};
    if (rd_step) begin
      shift_d = cur_in_range ? rd_data : '0;
    end
  end

  always_ff @(posedge spi_clk or negedge full_rstn) begin
    if (!full_rstn) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign rd_addr     = (state_q == READ) ? cur_addr : '0;
  assign poci        = shift_q[BYTE_W-1];
  assign unused_bits = byte_deser[BYTE_W-1];
`else
  assign rd_step     = 1'b0;
  assign rd_err      = 1'b0;
  assign rd_addr     = '0;
  assign poci        = 1'b0;
  assign unused_bits = ^{byte_deser[BYTE_W-1], rd_data};
`endif

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: directed test-plan transactions plus random bursts
// checked edge-by-edge against a transaction-level reference model.
module tb_spi_cmd_ctrl;

  localparam int ADDR_W   = 7;
  localparam int NUM_REGS = 64;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic              spi_clk    = 1'b0;
  logic              full_rstn  = 1'b0;
  logic              pico       = 1'b0;
  logic [7:0]        byte_deser = 8'h00;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              poci;
  logic              addr_err;

  logic [7:0] regs [128];
  logic       clk_en = 1'b0;
  logic [7:0] tx [$];

  int checks   = 0;
  int failures = 0;

  assign rd_data = regs[rd_addr];

  spi_cmd_ctrl #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .spi_clk    (spi_clk),
    .full_rstn  (full_rstn),
    .pico       (pico),
    .byte_deser (byte_deser),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .poci       (poci),
    .addr_err   (addr_err)
  );

  // Gated clock: once disabled it finishes any high phase and parks low.
  always begin
    #5;
    if (clk_en || spi_clk) spi_clk = ~spi_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Address after n auto-increments from a.
  function automatic int step_addr(input int a, input int n);
    int r = a;
    for (int i = 0; i < n; i++) r = (r == NUM_REGS - 1) ? 0 : (r + 1) % 128;
    return r;
  endfunction

  // Expected outputs after e clock edges of the current transaction in tx.
  task automatic check_state(input int e, input string ph);
    int         nb      = e / 8;
    int         pos     = e % 8;
    logic       exp_wen = 1'b0;
    logic       exp_err = 1'b0;
    logic       exp_poci = 1'b0;
    int         exp_rd  = 0;
    int         exp_wa  = 0;
    logic [7:0] exp_wd  = 8'h00;
    logic [7:0] rb;
    logic       is_wr;
    int         a0;
    if (nb >= 1) begin
      is_wr = tx[0][7];
      a0    = int'(tx[0][6:0]);
      for (int d = 1; d < nb; d++)
        if ((is_wr || RB) && step_addr(a0, d - 1) >= NUM_REGS) exp_err = 1'b1;
      if (is_wr && nb >= 2 && pos == 0 && step_addr(a0, nb - 2) < NUM_REGS) begin
        exp_wen = 1'b1;
        exp_wa  = step_addr(a0, nb - 2);
        exp_wd  = tx[nb-1];
      end
      if (!is_wr && RB) begin
        exp_rd = step_addr(a0, nb - 1);
        if (nb >= 2) begin
          rb       = (step_addr(a0, nb - 2) < NUM_REGS) ? regs[step_addr(a0, nb - 2)] : 8'h00;
          exp_poci = rb[7-pos];
        end
      end
    end
    check({ph, ".wr_en"}, 32'(wr_en), 32'(exp_wen));
    if (exp_wen) begin
      check({ph, ".wr_addr"}, 32'(wr_addr), 32'(exp_wa));
      check({ph, ".wr_data"}, 32'(wr_data), 32'(exp_wd));
    end
    check({ph, ".addr_err"}, 32'(addr_err), 32'(exp_err));
    check({ph, ".poci"}, 32'(poci), 32'(exp_poci));
    check({ph, ".rd_addr"}, 32'(rd_addr), 32'(exp_rd));
  endtask

  // One cs-framed transaction: full bytes from tx, then part_bits bits of part_val (MSB first).
  task automatic run_txn(input int part_bits, input logic [7:0] part_val, input string name);
    int   total = 8 * tx.size() + part_bits;
    logic b;
    byte_deser = 8'h00;
    full_rstn  = 1'b1;
    #2;
    check_state(0, {name, "/start"});
    for (int i = 0; i < total; i++) begin
      b = (i / 8 < tx.size()) ? tx[i/8][7 - i%8] : part_val[7 - i%8];
      pico   = b;
      clk_en = 1'b1;
      @(posedge spi_clk);
      #1 byte_deser = {byte_deser[6:0], b};
      @(negedge spi_clk);
      check_state(i + 1, $sformatf("%s/e%0d", name, i + 1));
    end
    clk_en = 1'b0;
    #40;
    check_state(total, {name, "/hold"});
    full_rstn = 1'b0;
    #1;
    check({name, "/rst.wr_en"}, 32'(wr_en), 32'd0);
    check({name, "/rst.wr_addr"}, 32'(wr_addr), 32'd0);
    check({name, "/rst.wr_data"}, 32'(wr_data), 32'd0);
    check({name, "/rst.addr_err"}, 32'(addr_err), 32'd0);
    check({name, "/rst.poci"}, 32'(poci), 32'd0);
    check({name, "/rst.rd_addr"}, 32'(rd_addr), 32'd0);
    #5;
  endtask

  initial begin
    int n;
    int pb;
    for (int i = 0; i < 128; i++) regs[i] = 8'($urandom);
    regs[2] = 8'hC3;
    regs[3] = 8'h5A;

    #12;
    check("reset.wr_en", 32'(wr_en), 32'd0);
    check("reset.wr_addr", 32'(wr_addr), 32'd0);
    check("reset.wr_data", 32'(wr_data), 32'd0);
    check("reset.addr_err", 32'(addr_err), 32'd0);
    check("reset.poci", 32'(poci), 32'd0);
    check("reset.rd_addr", 32'(rd_addr), 32'd0);

    tx = {8'h85, 8'hA5};               run_txn(0, 8'h00, "single");
    tx = {8'h85, 8'h11, 8'h22, 8'h33}; run_txn(0, 8'h00, "burst");
    tx = {8'hBF, 8'hAA, 8'hBB};        run_txn(0, 8'h00, "wrap63");
    tx = {8'hD0, 8'h55};               run_txn(0, 8'h00, "oor");
    tx = {8'hFF, 8'h01, 8'h02};        run_txn(0, 8'h00, "wrap127");
    tx = {8'h85};                      run_txn(5, 8'($urandom), "partial");
    tx = {8'h83, 8'h7E};               run_txn(0, 8'h00, "after_partial");
    tx = {8'h02, 8'h00, 8'h00, 8'h00}; run_txn(0, 8'h00, "readback");

    for (int t = 0; t < 24; t++) begin
      tx.delete();
      tx.push_back(8'($urandom_range(0, 255)));
      n = $urandom_range(0, 5);
      repeat (n) tx.push_back(8'($urandom));
      pb = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
      run_txn(pb, 8'($urandom), $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
